sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 Parameter DW, default 32, SRAM data width.
REQ-002 Parameter AW, default 9, SRAM word-address width (512 words).
REQ-003 Parameter BURST_MAX, default 8, max consecutive locked grants to one port while the other waits.
REQ-004 Reset and clock: reset hresetn, asynchronous, active-low; clock hclk.
REQ-005 hclk  in  1  clock; hresetn  in  1  async active-low reset.
REQ-006 a_req  in  1  port A (AHB BIU side) access request, held until granted.
REQ-007 a_we  in  1  port A write(1)/read(0); a_lock  in  1  port A requests back-to-back ownership.
REQ-008 a_addr  in  AW  port A word address; a_wdata  in  DW  port A write data.
REQ-009 a_gnt  out  1  port A access issued this cycle; a_rvalid  out  1  port A read data valid; a_rdata  out  DW  port A read data.
REQ-010 b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (engine side), identical widths and meaning.
REQ-011 sram_cs  out  1; sram_we  out  1; sram_addr  out  AW; sram_wdata  out  DW; sram_rdata  in  DW (1-cycle read latency).

Function
REQ-012 At most one SRAM access per cycle; sram_cs=1 only in a cycle where exactly one of a_gnt/b_gnt is 1.
REQ-013 Grant is combinational from req and registered arbiter state; in the granted cycle, sram_we/addr/wdata come from the winner.
REQ-014 With sram_cs=0, sram_we=0, sram_addr=0 and sram_wdata=0.
REQ-015 Only one port requesting: it wins the same cycle, with zero wait.
REQ-016 Both requesting, owner locked: if owner's lock=1 and beat_cnt<BURST_MAX, the owner wins.
REQ-017 Both requesting, otherwise: the port not granted last wins (round-robin pointer last_gnt).
REQ-018 FSM states IDLE, OWN_A, OWN_B; any grant moves to the winner's OWN state; a cycle with no grant moves to IDLE.
REQ-019 beat_cnt (width clog2(BURST_MAX)+1): grant to the current owner increments, saturating at BURST_MAX; grant to a new owner loads 1; no grant clears it to 0.
REQ-020 last_gnt updates on every grant to the winning port; it holds in idle cycles.
REQ-021 x_rvalid is registered: 1 exactly one cycle after a read grant to port x, otherwise 0.
REQ-022 a_rdata and b_rdata both pass sram_rdata through; data is meaningful only with the port's rvalid.
REQ-023 Write completes in the grant cycle; no rvalid is generated for writes.
REQ-024 Back-to-back read grants give back-to-back rvalid pulses; read-then-write to the same port in consecutive cycles is legal.
REQ-025 Lock deasserted mid-burst: the next arbitration uses round-robin immediately.
REQ-026 beat_cnt reaching BURST_MAX with the other port requesting: the other port wins the next cycle, even with lock held.

Reset
REQ-027 While hresetn=0: FSM=IDLE, beat_cnt=0, last_gnt=B (A wins the first tie), a_rvalid=b_rvalid=0, and a_gnt=b_gnt=sram_cs=sram_we=0 regardless of req.
REQ-028 Reset asserted mid-operation: pending rvalid is dropped; state returns to IDLE asynchronously.
REQ-029 First grant after release is possible in the first hclk edge cycle with hresetn=1.

Structure
REQ-030 Shared package sram_arb_pkg holds DW/AW defaults, BURST_MAX, and the state enum {IDLE, OWN_A, OWN_B}.
REQ-031 One sub-module, sram_arb_rr2, holds the 2-way round-robin/lock priority logic (req, lock, last_gnt, beat_cnt -> winner); datapath muxing and registers stay in sram_port_arb.

Verification
REQ-032 a_req only, read addr 0x05 -> a_gnt=1 and sram_addr=0x05, sram_we=0 that cycle; next cycle a_rvalid=1 with a_rdata equal to the preloaded word.
REQ-033 a_req and b_req held continuously, locks 0, after reset -> grants alternate A,B,A,B; no cycle has both gnts.
REQ-034 a_lock=1 with a_req and b_req continuous, BURST_MAX=8 -> 8 A grants, then 1 B grant, then A again.
REQ-035 b write 0xDEADBEEF to 0x1FF, then a read of 0x1FF in the next cycle -> a_rdata=0xDEADBEEF with a_rvalid one cycle after a_gnt.
REQ-036 hresetn pulsed low the cycle after an A read grant -> a_rvalid stays 0; after release, with both requesting, A wins first.
REQ-037 No requests for 3 cycles between grants -> sram_cs=0, FSM in IDLE, beat_cnt=0, last_gnt unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default widths, burst limit,
// ownership states and the beat-counter width helper.
package sram_arb_pkg;

    localparam int unsigned DW_DEF        = 32;
    localparam int unsigned AW_DEF        = 9;
    localparam int unsigned BURST_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Beat counter must hold the value BURST_MAX itself.
    function automatic int unsigned beat_w(input int unsigned bmax);
        return $clog2(bmax) + 1;
    endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way winner selection: lone requester wins, a locked owner below its burst
// limit keeps the port, otherwise the port not granted last wins.
module sram_arb_rr2
    import sram_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned CW        = beat_w(BURST_MAX)
) (
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_lock,
    input  logic          b_lock,
    input  logic          a_own,
    input  logic          b_own,
    input  logic          last_b,
    input  logic [CW-1:0] beat_cnt,
    output logic          a_win_c,
    output logic          b_win_c
);

    logic under_max;

    assign under_max = (beat_cnt < CW'(BURST_MAX));

    always_comb begin
        a_win_c = 1'b0;
        b_win_c = 1'b0;
        if (a_req && !b_req) begin
            a_win_c = 1'b1;
        end else if (b_req && !a_req) begin
            b_win_c = 1'b1;
        end else if (a_req && b_req) begin
            if (a_own && a_lock && under_max) begin
                a_win_c = 1'b1;
            end else if (b_own && b_lock && under_max) begin
                b_win_c = 1'b1;
            end else if (last_b) begin
                a_win_c = 1'b1;
            end else begin
                b_win_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arb.sv
// Single-port SRAM shared between the AHB BIU (port A) and the engine (port B):
// one access per cycle, zero-wait combinational grant, registered read-valid.
module sram_port_arb
    import sram_arb_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic          hclk,
    input  logic          hresetn,

    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam int unsigned CW = beat_w(BURST_MAX);

    arb_state_e    state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    port_e         last_gnt, last_gnt_nxt;
    logic          a_win_c, b_win_c;

    sram_arb_rr2 #(
        .BURST_MAX (BURST_MAX),
        .CW        (CW)
    ) u_rr2 (
        .a_req    (a_req),
        .b_req    (b_req),
        .a_lock   (a_lock),
        .b_lock   (b_lock),
        .a_own    (state == OWN_A),
        .b_own    (state == OWN_B),
        .last_b   (last_gnt == PORT_B),
        .beat_cnt (beat_cnt),
        .a_win_c  (a_win_c),
        .b_win_c  (b_win_c)
    );

    // Grants are suppressed while reset is held, whatever the requests do.
    assign a_gnt   = a_win_c & hresetn;
    assign b_gnt   = b_win_c & hresetn;
    assign sram_cs = a_gnt | b_gnt;

    assign a_rdata = sram_rdata;
    assign b_rdata = sram_rdata;

    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (a_gnt) begin
            sram_we    = a_we;
            sram_addr  = a_addr;
            sram_wdata = a_wdata;
        end else if (b_gnt) begin
            sram_we    = b_we;
            sram_addr  = b_addr;
            sram_wdata = b_wdata;
        end
    end

    // Ownership, burst length and round-robin pointer follow the winner.
    always_comb begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
        last_gnt_nxt = last_gnt;
        if (a_gnt) begin
            state_nxt    = OWN_A;
            last_gnt_nxt = PORT_A;
            if (state == OWN_A) begin
                beat_cnt_nxt = (beat_cnt == CW'(BURST_MAX)) ? beat_cnt : beat_cnt + CW'(1);
            end else begin
                beat_cnt_nxt = CW'(1);
            end
        end else if (b_gnt) begin
            state_nxt    = OWN_B;
            last_gnt_nxt = PORT_B;
            if (state == OWN_B) begin
                beat_cnt_nxt = (beat_cnt == CW'(BURST_MAX)) ? beat_cnt : beat_cnt + CW'(1);
            end else begin
                beat_cnt_nxt = CW'(1);
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_gnt <= PORT_B;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Read data arrives one cycle after the grant, matching the SRAM latency.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a 1-cycle-latency SRAM model.
module tb_sram_port_arb;
    import sram_arb_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [8:0]  a_addr, b_addr, sram_addr;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, sram_wdata, sram_rdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, sram_cs, sram_we;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem [512];
    bit          written [512];

    sram_port_arb dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_lock     (a_lock),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_lock     (b_lock),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .b_rdata    (b_rdata),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Unwritten words read back as 0xA500_0000 | address.
    always @(posedge hclk) begin
        if (sram_cs) begin
            if (sram_we) begin
                mem[sram_addr]     <= sram_wdata;
                written[sram_addr] <= 1'b1;
            end else begin
                sram_rdata <= written[sram_addr] ? mem[sram_addr] : (32'hA500_0000 | 32'(sram_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_alt;
        logic [9:0] exp_lock;
        exp_alt  = 4'b0101;
        exp_lock = 10'b10_1111_1111;

        // Reset held with both ports requesting: nothing may be granted.
        idle_inputs();
        hresetn = 1'b0;
        a_req = 1'b1; a_we = 1'b1; b_req = 1'b1;
        cyc();
        cyc();
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_cs", sram_cs, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_beat", 32'(dut.beat_cnt), 0);
        chk("rst_last", 32'(dut.last_gnt), 32'(PORT_B));

        // Release and issue an A read of 0x05 in the very first cycle.
        idle_inputs();
        hresetn = 1'b1;
        a_req = 1'b1; a_addr = 9'h005;
        #1;
        chk("rd5_a_gnt", a_gnt, 1);
        chk("rd5_b_gnt", b_gnt, 0);
        chk("rd5_cs", sram_cs, 1);
        chk("rd5_we", sram_we, 0);
        chk("rd5_addr", 32'(sram_addr), 32'h005);
        cyc();
        a_req = 1'b0;
        #1;
        chk("rd5_a_rvalid", a_rvalid, 1);
        chk("rd5_a_rdata", a_rdata, 32'hA500_0005);
        chk("rd5_b_rvalid", b_rvalid, 0);
        chk("idle_cs", sram_cs, 0);
        chk("idle_addr", 32'(sram_addr), 0);
        chk("idle_wdata", sram_wdata, 0);

        // Three idle cycles between grants.
        cyc();
        cyc();
        cyc();
        chk("gap_cs", sram_cs, 0);
        chk("gap_state", 32'(dut.state), 32'(IDLE));
        chk("gap_beat", 32'(dut.beat_cnt), 0);
        chk("gap_last", 32'(dut.last_gnt), 32'(PORT_A));
        chk("gap_a_rvalid", a_rvalid, 0);

        // A read granted, then reset pulsed right after the grant edge.
        a_req = 1'b1; a_addr = 9'h007;
        #1;
        chk("rrst_a_gnt", a_gnt, 1);
        cyc();
        hresetn = 1'b0;
        #1;
        chk("rrst_a_rvalid", a_rvalid, 0);
        chk("rrst_a_gnt_held", a_gnt, 0);
        chk("rrst_state", 32'(dut.state), 32'(IDLE));
        cyc();

        // Both ports requesting without lock after release: A,B,A,B.
        hresetn = 1'b1;
        a_req = 1'b1; a_addr = 9'h010;
        b_req = 1'b1; b_addr = 9'h020;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_a_gnt", a_gnt, exp_alt[i]);
            chk("alt_b_gnt", b_gnt, !exp_alt[i]);
            chk("alt_cs", sram_cs, 1);
            if (i > 0) begin
                chk("alt_a_rvalid", a_rvalid, exp_alt[i-1]);
                chk("alt_b_rvalid", b_rvalid, !exp_alt[i-1]);
                if (exp_alt[i-1]) chk("alt_a_rdata", a_rdata, 32'hA500_0010);
                else              chk("alt_b_rdata", b_rdata, 32'hA500_0020);
            end else begin
                chk("alt_first_a_rvalid", a_rvalid, 0);
            end
            cyc();
        end

        // A locked: eight A grants, one B grant, then A again.
        a_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("lock_a_gnt", a_gnt, exp_lock[i]);
            chk("lock_b_gnt", b_gnt, !exp_lock[i]);
            chk("lock_beat", 32'(dut.beat_cnt), (i == 0 || i == 9) ? 1 : i);
            cyc();
        end

        // A alone and locked: beat count saturates, then B takes over at once.
        b_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("sat_a_gnt", a_gnt, 1);
            cyc();
        end
        chk("sat_beat", 32'(dut.beat_cnt), 8);
        b_req = 1'b1;
        #1;
        chk("sat_b_gnt", b_gnt, 1);
        chk("sat_a_gnt_blocked", a_gnt, 0);
        cyc();
        idle_inputs();
        cyc();

        // B writes 0x1FF, A reads it back in the following cycle.
        b_req = 1'b1; b_we = 1'b1; b_addr = 9'h1FF; b_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_b_gnt", b_gnt, 1);
        chk("wr_we", sram_we, 1);
        chk("wr_addr", 32'(sram_addr), 32'h1FF);
        chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
        cyc();
        idle_inputs();
        a_req = 1'b1; a_addr = 9'h1FF;
        #1;
        chk("wb_a_gnt", a_gnt, 1);
        chk("wb_we", sram_we, 0);
        chk("wb_b_rvalid", b_rvalid, 0);
        cyc();
        a_req = 1'b0;
        #1;
        chk("wb_a_rvalid", a_rvalid, 1);
        chk("wb_a_rdata", a_rdata, 32'hDEAD_BEEF);
        cyc();

        // Read then write on port A in consecutive cycles.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h006;
        cyc();
        a_we = 1'b1; a_addr = 9'h006; a_wdata = 32'h1234_5678;
        #1;
        chk("rw_a_gnt", a_gnt, 1);
        chk("rw_we", sram_we, 1);
        chk("rw_a_rvalid", a_rvalid, 1);
        chk("rw_a_rdata", a_rdata, 32'hA500_0006);
        cyc();
        idle_inputs();
        #1;
        chk("rw_no_rvalid", a_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
